// File: rtl/shift_pkg.sv
// Shared types and opcode constants for the sequential shift unit.
// Imported by the decoder, the unit top and the ALU result mux.
package shift_pkg;

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_SRL = 5'b00110;

  typedef enum logic [1:0] {
    MODE_SLL,
    MODE_SRL,
    MODE_SRA
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_op_decode.sv
// ALU opcode to shift-mode decode.
// Also drives the result-mux select in the ALU.
module shift_op_decode
  import shift_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output shift_mode_t         mode,
  output logic                legal
);

  always_comb begin
    mode  = MODE_SLL;
    legal = 1'b0;
    unique case (1'b1)
      (opcode == OPCODE_W'(OP_SLL)): begin
        mode  = MODE_SLL;
        legal = 1'b1;
      end
      (opcode == OPCODE_W'(OP_SRL)): begin
        mode  = MODE_SRL;
        legal = 1'b1;
      end
      (opcode == OPCODE_W'(OP_SRA)): begin
        mode  = MODE_SRA;
        legal = 1'b1;
      end
      default: begin
        mode  = MODE_SLL;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative SLL/SRL/SRA unit, STEP bits per cycle,
// valid/ready on both sides.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SHAMT_W  = $clog2(WIDTH),
  parameter int OPCODE_W = 5,
  parameter int STEP     = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SHAMT_W-1:0]  in_shamt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_illegal,
  output logic                busy
);

  // One extra bit so STEP == 2**SHAMT_W still fits.
  localparam int KW = SHAMT_W + 1;

  state_t            state;
  state_t            state_n;
  shift_mode_t       mode;
  shift_mode_t       dec_mode;
  logic              dec_legal;
  logic              illegal;
  logic              take;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_sh;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_n;
  logic [KW-1:0]     k;

  shift_op_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .opcode(ctrl_ALUopcode),
    .mode  (dec_mode),
    .legal (dec_legal)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign take        = in_valid && in_ready;
  assign out_data    = acc;
  assign out_illegal = illegal;

  always_comb begin
    k = {1'b0, cnt};
    if ({1'b0, cnt} >= KW'(STEP)) begin
      k = KW'(STEP);
    end
  end

  assign cnt_n = cnt - k[SHAMT_W-1:0];

  // Small mux of constant shifts, 1..STEP, instead of a barrel.
  always_comb begin
    acc_sh = acc;
    for (int i = 1; i <= STEP; i++) begin
      if (k == KW'(i)) begin
        unique case (mode)
          MODE_SLL: acc_sh = acc << i;
          MODE_SRL: acc_sh = acc >> i;
          MODE_SRA: acc_sh = $unsigned($signed(acc) >>> i);
          default:  acc_sh = acc;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          if (!dec_legal || in_shamt == '0) begin
            state_n = DONE;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt_n == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      cnt     <= '0;
      mode    <= MODE_SLL;
      illegal <= 1'b0;
    end else if (take) begin
      acc     <= in_data;
      cnt     <= dec_legal ? in_shamt : '0;
      mode    <= dec_mode;
      illegal <= !dec_legal;
    end else if (state == SHIFT) begin
      acc <= acc_sh;
      cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench: STEP=1 and STEP=4 instances of shift_seq_unit.
// Expected results come from a reference shift model.
module tb_shift_seq_unit;

  localparam logic [4:0] SLL = 5'b00100;
  localparam logic [4:0] SRA = 5'b00101;
  localparam logic [4:0] SRL = 5'b00110;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        iv  [2];
  logic        ir  [2];
  logic        ov  [2];
  logic        orr [2];
  logic        ill [2];
  logic        bz  [2];
  logic [4:0]  opc [2];
  logic [31:0] din [2];
  logic [31:0] dout[2];
  logic [4:0]  sh  [2];

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  shift_seq_unit #(.STEP(1)) u_s1 (
    .clock(clock), .resetn(resetn),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .ctrl_ALUopcode(opc[0]),
    .in_data(din[0]), .in_shamt(sh[0]),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .out_data(dout[0]), .out_illegal(ill[0]),
    .busy(bz[0])
  );

  shift_seq_unit #(.STEP(4)) u_s4 (
    .clock(clock), .resetn(resetn),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .ctrl_ALUopcode(opc[1]),
    .in_data(din[1]), .in_shamt(sh[1]),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .out_data(dout[1]), .out_illegal(ill[1]),
    .busy(bz[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int u,
                                 input logic [4:0] op,
                                 input logic [31:0] d,
                                 input logic [4:0] s);
    exp_t e;
    int   step;
    step  = (u == 0) ? 1 : 4;
    e.ill = 1'b0;
    case (op)
      SLL: e.data = d << s;
      SRL: e.data = d >> s;
      SRA: e.data = $unsigned($signed(d) >>> s);
      default: begin
        e.data = d;
        e.ill  = 1'b1;
      end
    endcase
    if (e.ill || s == 0) e.lat = 1;
    else e.lat = (int'(s) + step - 1) / step + 1;
    return e;
  endfunction

  task automatic run(input int u,
                     input logic [4:0] op,
                     input logic [31:0] d,
                     input logic [4:0] s,
                     input int bp);
    exp_t e;
    int   edges;
    @(negedge clock);
    chk("ready_before", 32'(ir[u]), 32'd1);
    opc[u] = op;
    din[u] = d;
    sh[u]  = s;
    iv[u]  = 1'b1;
    sb.push_back(model(u, op, d, s));
    @(posedge clock);
    edges = 1;
    #1;
    iv[u]  = 1'b0;
    opc[u] = SRA;
    din[u] = ~d;
    sh[u]  = ~s;
    while (!ov[u] && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
    end
    if (!ov[u]) begin
      failures++;
      $display("FAIL timeout: unit=%0d no out_valid", u);
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: unit=%0d", u);
      return;
    end
    e = sb.pop_front();
    chk("data", dout[u], e.data);
    chk("illegal", 32'(ill[u]), 32'(e.ill));
    chk("latency", 32'(edges), 32'(e.lat));
    for (int i = 0; i < bp; i++) begin
      iv[u]  = 1'b1;
      din[u] = 32'hDEAD_BEEF;
      @(posedge clock);
      #1;
      chk("bp_valid", 32'(ov[u]), 32'd1);
      chk("bp_data", dout[u], e.data);
      chk("bp_ready", 32'(ir[u]), 32'd0);
    end
    iv[u]  = 1'b0;
    orr[u] = 1'b1;
    @(posedge clock);
    #1;
    orr[u] = 1'b0;
    chk("idle_ready", 32'(ir[u]), 32'd1);
    chk("idle_valid", 32'(ov[u]), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u]  = 1'b0;
      orr[u] = 1'b0;
      opc[u] = '0;
      din[u] = '0;
      sh[u]  = '0;
    end
    #12;
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_data", dout[0], 32'd0);
    chk("rst_ill", 32'(ill[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_ready", 32'(ir[0]), 32'd1);
    @(negedge clock);
    resetn = 1'b1;

    run(0, SLL, 32'h0000_0001, 5'd31, 0);
    run(0, SRA, 32'h8000_0000, 5'd4, 0);
    run(0, SRL, 32'h8000_0000, 5'd4, 0);
    run(0, SLL, 32'h1234_5678, 5'd0, 0);
    run(0, 5'b00000, 32'h1234_5678, 5'd9, 0);
    run(0, SRL, 32'hFFFF_0000, 5'd8, 3);
    run(1, SLL, 32'h0000_000F, 5'd7, 0);
    run(1, SRA, 32'h8765_4321, 5'd31, 1);
    run(1, SRL, 32'hF000_000F, 5'd4, 0);

    for (int i = 0; i < 8; i++) begin
      logic [4:0] op;
      case (i % 4)
        0: op = SLL;
        1: op = SRA;
        2: op = SRL;
        default: op = 5'($urandom_range(0, 31));
      endcase
      run(i % 2, op, $urandom, 5'($urandom_range(0, 31)), i % 3);
    end

    @(negedge clock);
    opc[0] = SLL;
    din[0] = 32'h0000_0001;
    sh[0]  = 5'd31;
    iv[0]  = 1'b1;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    chk("mid_busy", 32'(bz[0]), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mr_valid", 32'(ov[0]), 32'd0);
    chk("mr_data", dout[0], 32'd0);
    chk("mr_busy", 32'(bz[0]), 32'd0);
    chk("mr_ready", 32'(ir[0]), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    run(0, SRA, 32'h8000_0001, 5'd31, 0);
    run(1, SLL, 32'h0000_0003, 5'd30, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
